// File: rtl/mult_control_unit.sv
// mult_control_unit
//
// Sequencer for a serial add/shift (Booth-style last-step subtract) multiplier
// built around an X:A:B shift chain. One Run request produces exactly one
// multiply of WIDTH add/shift iterations; the result is then held (Done) until
// Run is released.
//
// Build option:
//   MULT_AUTO_CLEAR_EN  when defined, a CLEAR state clears A/X once before the
//                       first ADD. When undefined, A keeps its prior value so
//                       multiplies can be chained on the previous result.
//
// Parameters:
//   WIDTH         number of add/shift iterations per multiply (2..16)
//
// Ports:
//   Clk           system clock, rising edge
//   Reset         synchronous, active-high
//   Run           level start request (debounced, synchronized)
//   ClearA_LoadB  level request to clear A and load B (honoured in IDLE only)
//   M             current multiplier LSB from the B register
//   Load_B        parallel-load strobe for B
//   Clr_A         clear strobe for A and the X sign flop
//   Shift_En      arithmetic right-shift strobe for X:A:B
//   Add_En        latch A+S into X:A
//   Sub_En        latch A-S into X:A (last iteration only)
//   Busy          multiply in progress
//   Done          result held, waiting for Run to drop
//   Step          current iteration index
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for Run; services ClearA_LoadB
// CLEAR | one-cycle clear of A/X before the first add (option only)
// ADD   | conditional add (or subtract on the last step) when M=1
// SHIFT | one right shift of X:A:B, then next step or DONE
// DONE  | result held until Run returns low

module mult_control_unit #(
    parameter int WIDTH = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Run,
    input  logic                     ClearA_LoadB,
    input  logic                     M,
    output logic                     Load_B,
    output logic                     Clr_A,
    output logic                     Shift_En,
    output logic                     Add_En,
    output logic                     Sub_En,
    output logic                     Busy,
    output logic                     Done,
    output logic [$clog2(WIDTH)-1:0] Step
);

    localparam int              SW        = $clog2(WIDTH);
    localparam logic [SW-1:0]   LAST_STEP = SW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
`ifdef MULT_AUTO_CLEAR_EN
        CLEAR = 3'd1,
`endif
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   step_q, step_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        Load_B   = 1'b0;
        Clr_A    = 1'b0;
        Shift_En = 1'b0;
        Add_En   = 1'b0;
        Sub_En   = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;

        case (state_q)
            IDLE: begin
                step_d = '0;
                // Run wins over ClearA_LoadB so a start never disturbs B.
                if (Run) begin
`ifdef MULT_AUTO_CLEAR_EN
                    state_d = CLEAR;
`else
                    state_d = ADD;
`endif
                end else if (ClearA_LoadB) begin
                    Load_B = 1'b1;
                    Clr_A  = 1'b1;
                end
            end
`ifdef MULT_AUTO_CLEAR_EN
            CLEAR: begin
                Busy    = 1'b1;
                Clr_A   = 1'b1;
                step_d  = '0;
                state_d = ADD;
            end
`endif
            ADD: begin
                Busy = 1'b1;
                // The final partial product carries negative weight in two's
                // complement, hence subtract on the last step.
                if (step_q == LAST_STEP) begin
                    Sub_En = M;
                end else begin
                    Add_En = M;
                end
                state_d = SHIFT;
            end
            SHIFT: begin
                Busy     = 1'b1;
                Shift_En = 1'b1;
                if (step_q == LAST_STEP) begin
                    step_d  = '0;
                    state_d = DONE;
                end else begin
                    step_d  = step_q + SW'(1);
                    state_d = ADD;
                end
            end
            DONE: begin
                Done = 1'b1;
                if (!Run) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                step_d  = '0;
            end
        endcase

        Step = step_q;
    end

endmodule

// File: tb/tb_mult_control_unit.sv
// Directed bench for mult_control_unit (WIDTH = 8). Expectations come from a
// small cycle model of the add/shift sequence; they adapt to MULT_AUTO_CLEAR_EN.

module tb_mult_control_unit;

    localparam int W = 8;
`ifdef MULT_AUTO_CLEAR_EN
    localparam int AC = 1;
`else
    localparam int AC = 0;
`endif

    logic       Clk;
    logic       Reset;
    logic       Run;
    logic       ClearA_LoadB;
    logic       M;
    logic       Load_B;
    logic       Clr_A;
    logic       Shift_En;
    logic       Add_En;
    logic       Sub_En;
    logic       Busy;
    logic       Done;
    logic [2:0] Step;

    int n_checks = 0;
    int n_fail   = 0;

    mult_control_unit #(.WIDTH(W)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .M            (M),
        .Load_B       (Load_B),
        .Clr_A        (Clr_A),
        .Shift_En     (Shift_En),
        .Add_En       (Add_En),
        .Sub_En       (Sub_En),
        .Busy         (Busy),
        .Done         (Done),
        .Step         (Step)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // {Busy, Done, Add_En, Sub_En, Shift_En, Clr_A, Load_B, Step[2:0]}
    function automatic int outs();
        return int'({Busy, Done, Add_En, Sub_En, Shift_En, Clr_A, Load_B, Step});
    endfunction

    function automatic int pack(input logic busy, input logic done, input logic add,
                                input logic sub, input logic shf, input logic clr,
                                input logic ldb, input int step);
        logic [2:0] s3;
        s3 = 3'(step);
        return int'({busy, done, add, sub, shf, clr, ldb, s3});
    endfunction

    // One full multiply. mpat[s] is the M value presented on step s.
    // total: number of edges Run stays high (at least up to DONE entry).
    task automatic run_mult(input string tag, input logic [7:0] mpat,
                            input logic clb, input int total);
        int done_k, last_k, j, s, adds, subs, shifts, e_adds;
        logic e_busy, e_done, e_add, e_sub, e_shf, e_clr;
        int e_step;
        done_k = 2 * W + 1 + AC;
        last_k = (total > done_k) ? total : done_k;
        adds = 0; subs = 0; shifts = 0;
        e_adds = 0;
        for (int i = 0; i < W - 1; i++) e_adds += int'(mpat[i]);

        Run = 1'b1; ClearA_LoadB = clb; M = 1'b0;
        #1;
        check({tag, "_idle_prio"}, int'({Load_B, Clr_A}), 0);

        for (int k = 1; k <= last_k; k++) begin
            tick();
            e_busy = 0; e_done = 0; e_add = 0; e_sub = 0; e_shf = 0; e_clr = 0;
            e_step = 0;
            M = 1'b1;
            if (AC == 1 && k == 1) begin
                e_busy = 1; e_clr = 1;
            end else if (k < done_k) begin
                j = k - AC;
                s = (j - 1) / 2;
                e_busy = 1; e_step = s;
                M = mpat[s];
                if (j % 2 == 1) begin
                    e_add = mpat[s] && (s < W - 1);
                    e_sub = mpat[s] && (s == W - 1);
                end else begin
                    e_shf = 1;
                end
            end else begin
                e_done = 1;
            end
            #1;
            check({tag, "_cyc"}, outs(),
                  pack(e_busy, e_done, e_add, e_sub, e_shf, e_clr, 1'b0, e_step));
            adds   += int'(Add_En);
            subs   += int'(Sub_En);
            shifts += int'(Shift_En);
        end
        check({tag, "_n_add"}, adds, e_adds);
        check({tag, "_n_sub"}, subs, int'(mpat[W-1]));
        check({tag, "_n_shift"}, shifts, W);

        Run = 1'b0; ClearA_LoadB = 1'b0; M = 1'b0;
        tick();
        check({tag, "_back_idle"}, outs(), 0);
    endtask

    initial begin
        int ldb_cnt;
        Reset = 1'b1; Run = 1'b0; ClearA_LoadB = 1'b0; M = 1'b0;
        tick();
        tick();
        check("reset_outs", outs(), 0);
        Reset = 1'b0;
        tick();
        check("post_reset_idle", outs(), 0);

        // ClearA_LoadB held 3 cycles in IDLE
        ldb_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            ClearA_LoadB = (i < 3);
            tick();
            check("clb_cyc", outs(),
                  pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, i < 3, i < 3, 0));
            ldb_cnt += int'(Load_B && Clr_A);
        end
        check("clb_count", ldb_cnt, 3);

        run_mult("m_all1", 8'hFF, 1'b0, 0);
        run_mult("m_1010", 8'h55, 1'b0, 0);
        run_mult("hold40", 8'h80, 1'b0, 40);
        run_mult("clb_run", 8'hA5, 1'b1, 0);

        // Reset in SHIFT at step 3, with Run and ClearA_LoadB also high
        Run = 1'b1; M = 1'b1;
        for (int k = 1; k <= 8 + AC; k++) tick();
        check("pre_abort_shift", int'({Shift_En, Busy, Step}), int'({1'b1, 1'b1, 3'd3}));
        Reset = 1'b1; ClearA_LoadB = 1'b1;
        tick();
        check("abort_reset", outs(), 0);
        Reset = 1'b0; Run = 1'b0; ClearA_LoadB = 1'b0; M = 1'b0;
        tick();
        check("abort_idle", outs(), 0);
        run_mult("fresh", 8'h3C, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

endmodule
